// File: rtl/axis_packet_sequencer_if.sv
// rtl/axis_packet_sequencer_if.sv - AXI-Stream channel bundle for the packet sequencer
//
// Purpose : groups the stream handshake signals of the sequencer output.
// Signals : tdata  [DW-1:0] payload (counter value)
//           tvalid           beat valid
//           tlast            last beat of packet
//           tready           sink ready
// Modports: master drives tdata/tvalid/tlast and samples tready;
//           slave samples tdata/tvalid/tlast and drives tready.
interface axis_packet_sequencer_if #(
    parameter int DW = 64
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_packet_sequencer.sv
// rtl/axis_packet_sequencer.sv - counting-stream packet sequencer for the AXI-Stream FIFO
//
// Purpose : emits the 64-bit counting stream as packets of programmable
//           length, with an optional packet count and an optional idle gap
//           between packets, honouring tready and never truncating a packet.
// Ports   : sys_clk_i      clock
//           sys_rst_i      synchronous reset, active-high
//           cfg_start_i    one-cycle start request
//           cfg_stop_i     one-cycle graceful stop request
//           cfg_pkt_len_i  beats per packet (0 is rejected)
//           cfg_pkt_num_i  packets per run, 0 = continuous
//           cfg_gap_i      idle cycles between packets, 0 = back-to-back
//           m_axis         stream output (master modport)
//           sts_busy_o     high while not idle
//           sts_done_o     pulse when a counted run completes
//           sts_err_o      pulse when a start is rejected
//           sts_pkt_cnt_o  packets completed since the last accepted start
module axis_packet_sequencer #(
    parameter int DW = 64,
    parameter int CW = 32,
    parameter int GW = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic                    cfg_start_i,
    input  logic                    cfg_stop_i,
    input  logic [CW-1:0]           cfg_pkt_len_i,
    input  logic [CW-1:0]           cfg_pkt_num_i,
    input  logic [GW-1:0]           cfg_gap_i,
    axis_packet_sequencer_if.master m_axis,
    output logic                    sts_busy_o,
    output logic                    sts_done_o,
    output logic                    sts_err_o,
    output logic [CW-1:0]           sts_pkt_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        r_state,        w_state;
    logic [CW-1:0] r_len,          w_len;
    logic [CW-1:0] r_num,          w_num;
    logic [GW-1:0] r_gap,          w_gap;
    logic [DW-1:0] r_tdata,        w_tdata;
    logic          r_tvalid,       w_tvalid;
    logic          r_tlast,        w_tlast;
    logic [CW-1:0] r_beat_cnt,     w_beat_cnt;
    logic [CW-1:0] r_pkt_cnt,      w_pkt_cnt;
    logic [GW-1:0] r_gap_cnt,      w_gap_cnt;
    logic          r_stop_pending, w_stop_pending;
    logic          r_busy,         w_busy;
    logic          r_done,         w_done;
    logic          r_err,          w_err;

    logic          w_beat_acc;
    logic [CW-1:0] w_beat_inc;
    logic [CW-1:0] w_pkt_inc;
    logic [CW-1:0] w_len_m1;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_num          <= '0;
            r_gap          <= '0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_beat_cnt     <= '0;
            r_pkt_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_len          <= w_len;
            r_num          <= w_num;
            r_gap          <= w_gap;
            r_tdata        <= w_tdata;
            r_tvalid       <= w_tvalid;
            r_tlast        <= w_tlast;
            r_beat_cnt     <= w_beat_cnt;
            r_pkt_cnt      <= w_pkt_cnt;
            r_gap_cnt      <= w_gap_cnt;
            r_stop_pending <= w_stop_pending;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_err          <= w_err;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_len          = r_len;
        w_num          = r_num;
        w_gap          = r_gap;
        w_tdata        = r_tdata;
        w_tvalid       = r_tvalid;
        w_tlast        = r_tlast;
        w_beat_cnt     = r_beat_cnt;
        w_pkt_cnt      = r_pkt_cnt;
        w_gap_cnt      = r_gap_cnt;
        w_stop_pending = r_stop_pending;
        w_busy         = r_busy;
        w_done         = 1'b0;
        w_err          = 1'b0;

        w_beat_acc = r_tvalid & m_axis.tready;
        w_beat_inc = r_beat_cnt + CW'(1);
        w_pkt_inc  = r_pkt_cnt + CW'(1);
        w_len_m1   = r_len - CW'(1);

        case (r_state)
            S_IDLE: begin
                // A simultaneous stop cancels the start outright.
                if (cfg_start_i && !cfg_stop_i) begin
                    if (cfg_pkt_len_i == '0) begin
                        w_err = 1'b1;
                    end else begin
                        w_state        = S_SEND;
                        w_len          = cfg_pkt_len_i;
                        w_num          = cfg_pkt_num_i;
                        w_gap          = cfg_gap_i;
                        w_tdata        = '0;
                        w_beat_cnt     = '0;
                        w_pkt_cnt      = '0;
                        w_tvalid       = 1'b1;
                        w_tlast        = (cfg_pkt_len_i == CW'(1));
                        w_busy         = 1'b1;
                        w_stop_pending = 1'b0;
                    end
                end
            end

            S_SEND: begin
                if (cfg_stop_i) begin
                    w_stop_pending = 1'b1;
                end
                // Without an accepted beat every output holds, which keeps
                // tdata/tlast stable across tready stalls.
                if (w_beat_acc) begin
                    w_tdata = r_tdata + DW'(1);
                    if (r_tlast) begin
                        w_pkt_cnt  = w_pkt_inc;
                        w_beat_cnt = '0;
                        if ((r_num != '0) && (w_pkt_inc == r_num)) begin
                            w_state        = S_IDLE;
                            w_tvalid       = 1'b0;
                            w_tlast        = 1'b0;
                            w_busy         = 1'b0;
                            w_stop_pending = 1'b0;
                            w_done         = 1'b1;
                        end else if (r_stop_pending || cfg_stop_i) begin
                            w_state        = S_IDLE;
                            w_tvalid       = 1'b0;
                            w_tlast        = 1'b0;
                            w_busy         = 1'b0;
                            w_stop_pending = 1'b0;
                        end else if (r_gap != '0) begin
                            w_state   = S_GAP;
                            w_gap_cnt = r_gap;
                            w_tvalid  = 1'b0;
                            w_tlast   = 1'b0;
                        end else begin
                            // Back-to-back: first beat of next packet offered immediately.
                            w_tlast = (r_len == CW'(1));
                        end
                    end else begin
                        w_beat_cnt = w_beat_inc;
                        w_tlast    = (w_beat_inc == w_len_m1);
                    end
                end
            end

            S_GAP: begin
                if (cfg_stop_i) begin
                    w_state        = S_IDLE;
                    w_busy         = 1'b0;
                    w_stop_pending = 1'b0;
                end else if (r_gap_cnt == GW'(1)) begin
                    w_state  = S_SEND;
                    w_tvalid = 1'b1;
                    w_tlast  = (r_len == CW'(1));
                end else begin
                    w_gap_cnt = r_gap_cnt - GW'(1);
                end
            end

            default: begin
                w_state  = S_IDLE;
                w_tvalid = 1'b0;
                w_tlast  = 1'b0;
                w_busy   = 1'b0;
            end
        endcase
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign sts_busy_o    = r_busy;
    assign sts_done_o    = r_done;
    assign sts_err_o     = r_err;
    assign sts_pkt_cnt_o = r_pkt_cnt;

endmodule
